// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle shared by the fetch/data requesters, the memory arbiter and the unified memory.
// The master modport is the arbiter's view; the slave modport is the requester/memory side.
interface mips_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_ack;
    logic [DW-1:0]   i_rdata;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;
    logic            d_err;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_ack,
        output i_ack, i_rdata, i_err,
        output d_ack, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_ack,
        input  i_ack, i_rdata, i_err,
        input  d_ack, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between MIPS instruction fetch and load/store, data-first with a
// fetch starvation limiter. Define MEM_TIMEOUT_EN to abort transactions that never see mem_ack.
module mips_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               rst,
    mips_mem_arbiter_if.master bus
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_DSTREAK);
    localparam logic [SW-1:0] STREAK_ONE  = SW'(32'd1);
    localparam logic [SW-1:0] STREAK_ZERO = {SW{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [SW-1:0] streak_r;
    logic [SW-1:0] streak_nx_s;

    logic          mem_req_r,   mem_req_nx_s;
    logic          mem_we_r,    mem_we_nx_s;
    logic [AW-1:0] mem_addr_r,  mem_addr_nx_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_nx_s;
    logic [BW-1:0] mem_be_r,    mem_be_nx_s;
    logic [DW-1:0] i_rdata_r,   i_rdata_nx_s;
    logic [DW-1:0] d_rdata_r,   d_rdata_nx_s;
    logic          i_ack_r,     i_ack_nx_s;
    logic          d_ack_r,     d_ack_nx_s;
    logic          i_err_r,     i_err_nx_s;
    logic          d_err_r,     d_err_nx_s;

    logic          grant_d_s;
    logic          grant_i_s;
    logic          busy_s;
    logic          expire_s;

    // Data wins unless fetch has already waited out MAX_DSTREAK consecutive data grants.
    always_comb begin
        grant_d_s = bus.d_req & ~(bus.i_req & (streak_r == STREAK_MAX));
        grant_i_s = bus.i_req & ~grant_d_s;
        busy_s    = (state_r == I_BUSY) || (state_r == D_BUSY);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(32'd1);

    logic [TW-1:0] tmo_cnt_r;

    // Counts BUSY edges without mem_ack; held at zero outside BUSY so every grant starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (!busy_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (!bus.mem_ack && (tmo_cnt_r != TMO_LAST)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // A real mem_ack on the expiry edge takes precedence over the abort.
    assign expire_s = busy_s & ~bus.mem_ack & (tmo_cnt_r == TMO_LAST);
`else
    logic unused_tmo_s;

    assign expire_s     = 1'b0;
    assign unused_tmo_s = (TIMEOUT > 32'sd0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: one transaction at a time, with a DONE gap before re-arbitration.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nx_s = D_BUSY;
                end else if (grant_i_s) begin
                    state_nx_s = I_BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ack || expire_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Next values of the registered bus outputs and the data-streak counter.
    always_comb begin
        streak_nx_s    = streak_r;
        mem_req_nx_s   = mem_req_r;
        mem_we_nx_s    = mem_we_r;
        mem_addr_nx_s  = mem_addr_r;
        mem_wdata_nx_s = mem_wdata_r;
        mem_be_nx_s    = mem_be_r;
        i_rdata_nx_s   = i_rdata_r;
        d_rdata_nx_s   = d_rdata_r;
        i_ack_nx_s     = 1'b0;
        d_ack_nx_s     = 1'b0;
        i_err_nx_s     = 1'b0;
        d_err_nx_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    mem_req_nx_s   = 1'b1;
                    mem_we_nx_s    = bus.d_we;
                    mem_addr_nx_s  = bus.d_addr;
                    mem_wdata_nx_s = bus.d_wdata;
                    mem_be_nx_s    = bus.d_be;
                    if (bus.i_req) begin
                        streak_nx_s = (streak_r == STREAK_MAX) ? STREAK_MAX : (streak_r + STREAK_ONE);
                    end else begin
                        streak_nx_s = STREAK_ZERO;
                    end
                end else if (grant_i_s) begin
                    mem_req_nx_s   = 1'b1;
                    mem_we_nx_s    = 1'b0;
                    mem_addr_nx_s  = bus.i_addr;
                    mem_wdata_nx_s = {DW{1'b0}};
                    mem_be_nx_s    = {BW{1'b0}};
                    streak_nx_s    = STREAK_ZERO;
                end else begin
                    mem_req_nx_s = 1'b0;
                end
            end
            I_BUSY: begin
                if (bus.mem_ack) begin
                    mem_req_nx_s = 1'b0;
                    i_ack_nx_s   = 1'b1;
                    i_rdata_nx_s = bus.mem_rdata;
                end else if (expire_s) begin
                    mem_req_nx_s = 1'b0;
                    i_ack_nx_s   = 1'b1;
                    i_err_nx_s   = 1'b1;
                end else begin
                    mem_req_nx_s = 1'b1;
                end
            end
            D_BUSY: begin
                if (bus.mem_ack) begin
                    mem_req_nx_s = 1'b0;
                    d_ack_nx_s   = 1'b1;
                    d_rdata_nx_s = bus.mem_rdata;
                end else if (expire_s) begin
                    mem_req_nx_s = 1'b0;
                    d_ack_nx_s   = 1'b1;
                    d_err_nx_s   = 1'b1;
                end else begin
                    mem_req_nx_s = 1'b1;
                end
            end
            DONE:    mem_req_nx_s = 1'b0;
            default: mem_req_nx_s = 1'b0;
        endcase
    end

    // Output and streak registers; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r    <= STREAK_ZERO;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            mem_be_r    <= {BW{1'b0}};
            i_rdata_r   <= {DW{1'b0}};
            d_rdata_r   <= {DW{1'b0}};
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            i_err_r     <= 1'b0;
            d_err_r     <= 1'b0;
        end else begin
            streak_r    <= streak_nx_s;
            mem_req_r   <= mem_req_nx_s;
            mem_we_r    <= mem_we_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            mem_be_r    <= mem_be_nx_s;
            i_rdata_r   <= i_rdata_nx_s;
            d_rdata_r   <= d_rdata_nx_s;
            i_ack_r     <= i_ack_nx_s;
            d_ack_r     <= d_ack_nx_s;
            i_err_r     <= i_err_nx_s;
            d_err_r     <= d_err_nx_s;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.i_ack     = i_ack_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.i_err     = i_err_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_err     = d_err_r;
endmodule
